// File: rtl/alu_control_md_seq_if.sv
// Decode/sequencer bundle between the control unit, the ALU control block and the ALU/MD datapath.
interface alu_control_md_seq_if #(
  parameter int ALU_OP_WIDTH = 5
);
  logic                    valid_i;
  logic                    flush_i;
  logic [6:0]              funct7_i;
  logic [2:0]              ALU_Op_i;
  logic [2:0]              funct3_i;
  logic                    div_by_zero_i;
  logic [ALU_OP_WIDTH-1:0] ALU_Operation_o;
  logic                    stall_o;
  logic                    md_start_o;
  logic [2:0]              md_op_o;
  logic                    md_done_o;

  modport master (
    output valid_i, flush_i, funct7_i, ALU_Op_i, funct3_i, div_by_zero_i,
    input  ALU_Operation_o, stall_o, md_start_o, md_op_o, md_done_o
  );

  modport slave (
    input  valid_i, flush_i, funct7_i, ALU_Op_i, funct3_i, div_by_zero_i,
    output ALU_Operation_o, stall_o, md_start_o, md_op_o, md_done_o
  );
endinterface

// File: rtl/alu_control_md_seq.sv
// ALU control with RV32I decode plus an IDLE/BUSY/DONE sequencer that stalls the
// pipeline for multi-cycle RV32M multiply/divide operations.
module alu_control_md_seq #(
  parameter int ALU_OP_WIDTH = 5,
  parameter int MUL_LATENCY  = 4,
  parameter int DIV_LATENCY  = 32
) (
  input logic                 clk,
  input logic                 reset,
  alu_control_md_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [5:0] MUL_CNT = 6'(MUL_LATENCY - 1);
  localparam logic [5:0] DIV_CNT = 6'(DIV_LATENCY - 1);

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MD   = 7'b0000001;

  state_t     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic [2:0] md_op_q, md_op_d;

  logic       is_m_op;
  logic       start_ok;
  logic       start_c, stall_c, done_c;
  logic [4:0] alu_code;

  // Shared ADD/AND/OR/XOR codes for the R and I formats.
  function automatic logic [4:0] logic_code(input logic [2:0] f3);
    logic [4:0] code;
    code = 5'b00000;
    case (f3)
      3'b000:  code = 5'b00000;
      3'b111:  code = 5'b00010;
      3'b110:  code = 5'b00011;
      3'b100:  code = 5'b00100;
      default: code = 5'b00000;
    endcase
    return code;
  endfunction

  function automatic logic [4:0] decode_op(input logic [6:0] f7,
                                           input logic [2:0] op,
                                           input logic [2:0] f3);
    logic [4:0] code;
    code = 5'b00000;
    case (op)
      3'b000: begin
        if (f7 == F7_BASE) begin
          case (f3)
            3'b101:  code = 5'b00110;
            3'b001:  code = 5'b00111;
            default: code = logic_code(f3);
          endcase
        end else if (f7 == F7_ALT) begin
          case (f3)
            3'b000:  code = 5'b00001;
            3'b101:  code = 5'b01110;
            default: code = 5'b00000;
          endcase
        end else if (f7 == F7_MD) begin
          code = {2'b10, f3};
        end
      end
      3'b001: begin
        case (f3)
          3'b101: begin
            if (f7 == F7_BASE)     code = 5'b00110;
            else if (f7 == F7_ALT) code = 5'b01110;
          end
          3'b001: begin
            if (f7 == F7_BASE) code = 5'b00111;
          end
          default: code = logic_code(f3);
        endcase
      end
      3'b101: begin
        case (f3)
          3'b000:  code = 5'b01000;
          3'b001:  code = 5'b01010;
          3'b100:  code = 5'b01011;
          3'b101:  code = 5'b01100;
          default: code = 5'b00000;
        endcase
      end
      3'b100:  code = 5'b00101;
      3'b110:  code = 5'b01101;
      // LW/SW, JALR and everything unmatched resolve to ADD.
      default: code = 5'b00000;
    endcase
    return code;
  endfunction

  assign is_m_op  = (bus.ALU_Op_i == 3'b000) && (bus.funct7_i == F7_MD);
  assign start_ok = bus.valid_i && is_m_op && !bus.flush_i;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    md_op_d  = md_op_q;
    start_c  = 1'b0;
    stall_c  = 1'b0;
    done_c   = 1'b0;
    alu_code = decode_op(bus.funct7_i, bus.ALU_Op_i, bus.funct3_i);
    case (state_q)
      IDLE: begin
        if (start_ok) begin
          start_c = 1'b1;
          stall_c = 1'b1;
          md_op_d = bus.funct3_i;
          if (bus.funct3_i[2] && bus.div_by_zero_i) begin
            state_d = DONE;
          end else begin
            state_d = BUSY;
            cnt_d   = bus.funct3_i[2] ? DIV_CNT : MUL_CNT;
          end
        end
      end
      BUSY: begin
        alu_code = {2'b10, md_op_q};
        if (bus.flush_i) begin
          state_d = IDLE;
          cnt_d   = 6'd0;
        end else begin
          stall_c = 1'b1;
          cnt_d   = cnt_q - 6'd1;
          if (cnt_q == 6'd1) state_d = DONE;
        end
      end
      DONE: begin
        alu_code = {2'b10, md_op_q};
        done_c   = !bus.flush_i;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 6'd0;
      md_op_q <= 3'b000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      md_op_q <= md_op_d;
    end
  end

  // Handshake outputs are held low for as long as reset is asserted.
  assign bus.stall_o         = stall_c && !reset;
  assign bus.md_start_o      = start_c && !reset;
  assign bus.md_done_o       = done_c && !reset;
  assign bus.md_op_o         = bus.md_start_o ? bus.funct3_i : md_op_q;
  assign bus.ALU_Operation_o = ALU_OP_WIDTH'(alu_code);

endmodule

// File: tb/tb_alu_control_md_seq.sv
// Directed bench for alu_control_md_seq: decode sweep, M-op sequencing, flush and reset.
module tb_alu_control_md_seq;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  alu_control_md_seq_if #(.ALU_OP_WIDTH(5)) bus ();

  alu_control_md_seq #(
    .ALU_OP_WIDTH(5),
    .MUL_LATENCY (4),
    .DIV_LATENCY (32)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-written decode table keyed by {funct7==0100000, ALU_Op, funct3}.
  function automatic logic [4:0] exp_decode(input logic alt, input logic [2:0] op,
                                            input logic [2:0] f3);
    logic [6:0] key;
    key = {alt, op, f3};
    casez (key)
      7'b0_000_000: return 5'b00000;
      7'b0_000_111: return 5'b00010;
      7'b0_000_110: return 5'b00011;
      7'b0_000_100: return 5'b00100;
      7'b0_000_101: return 5'b00110;
      7'b0_000_001: return 5'b00111;
      7'b1_000_000: return 5'b00001;
      7'b1_000_101: return 5'b01110;
      7'b?_001_000: return 5'b00000;
      7'b?_001_111: return 5'b00010;
      7'b?_001_110: return 5'b00011;
      7'b?_001_100: return 5'b00100;
      7'b0_001_101: return 5'b00110;
      7'b0_001_001: return 5'b00111;
      7'b1_001_101: return 5'b01110;
      7'b?_101_000: return 5'b01000;
      7'b?_101_001: return 5'b01010;
      7'b?_101_100: return 5'b01011;
      7'b?_101_101: return 5'b01100;
      7'b?_100_???: return 5'b00101;
      7'b?_110_???: return 5'b01101;
      default:      return 5'b00000;
    endcase
  endfunction

  task automatic set_in(input logic v, input logic fl, input logic [6:0] f7,
                        input logic [2:0] op, input logic [2:0] f3, input logic dz);
    bus.valid_i       = v;
    bus.flush_i       = fl;
    bus.funct7_i      = f7;
    bus.ALU_Op_i      = op;
    bus.funct3_i      = f3;
    bus.div_by_zero_i = dz;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_in(1'b1, 1'b0, 7'b0000001, 3'b000, 3'b000, 1'b0);
    #2;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({bus.stall_o, bus.md_start_o, bus.md_done_o, bus.md_op_o} !== 6'b0) begin
        errors++;
        $display("FAIL reset_outputs k=%0d: got stall/start/done/op=%b%b%b/%b want 000/000",
                 k, bus.stall_o, bus.md_start_o, bus.md_done_o, bus.md_op_o);
      end
      @(negedge clk);
    end
    bus.valid_i = 1'b0;
    reset = 1'b0;
    #1;
    checks++;
    if (bus.stall_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_stall: got %b want 0", bus.stall_o);
    end
  endtask

  task automatic test_decode();
    logic [6:0] f7;
    logic [4:0] exp;
    for (int a = 0; a < 2; a++) begin
      for (int op = 0; op < 8; op++) begin
        for (int f3 = 0; f3 < 8; f3++) begin
          @(negedge clk);
          f7 = (a == 1) ? 7'b0100000 : 7'b0000000;
          set_in(1'b1, 1'b0, f7, 3'(op), 3'(f3), 1'b0);
          exp = exp_decode(a[0], 3'(op), 3'(f3));
          #1;
          checks++;
          if (bus.ALU_Operation_o !== exp || bus.stall_o !== 1'b0 || bus.md_start_o !== 1'b0) begin
            errors++;
            $display("FAIL decode f7=%b op=%0d f3=%0d: got code=%b stall=%b start=%b want code=%b stall=0 start=0",
                     f7, op, f3, bus.ALU_Operation_o, bus.stall_o, bus.md_start_o, exp);
          end
        end
      end
    end
    @(negedge clk);
    bus.valid_i = 1'b0;
  endtask

  task automatic test_mul();
    logic [4:0] exp_stall, exp_start, exp_done;
    exp_stall = 5'b01111;
    exp_start = 5'b00001;
    exp_done  = 5'b10000;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 0) set_in(1'b1, 1'b0, 7'b0000001, 3'b000, 3'b000, 1'b0);
      if (c == 5) bus.valid_i = 1'b0;
      #1;
      if (c < 5) begin
        checks++;
        if (bus.stall_o !== exp_stall[c] || bus.md_start_o !== exp_start[c] ||
            bus.md_done_o !== exp_done[c] || bus.ALU_Operation_o !== 5'b10000) begin
          errors++;
          $display("FAIL mul c=%0d: got stall=%b start=%b done=%b code=%b want %b %b %b 10000",
                   c, bus.stall_o, bus.md_start_o, bus.md_done_o, bus.ALU_Operation_o,
                   exp_stall[c], exp_start[c], exp_done[c]);
        end
      end else begin
        checks++;
        if (bus.stall_o !== 1'b0 || bus.md_done_o !== 1'b0) begin
          errors++;
          $display("FAIL mul_after: got stall=%b done=%b want 0 0", bus.stall_o, bus.md_done_o);
        end
      end
    end
  endtask

  task automatic test_divu_by_zero();
    @(negedge clk);
    set_in(1'b1, 1'b0, 7'b0000001, 3'b000, 3'b101, 1'b1);
    #1;
    checks++;
    if (bus.stall_o !== 1'b1 || bus.md_start_o !== 1'b1 || bus.ALU_Operation_o !== 5'b10101) begin
      errors++;
      $display("FAIL divz_c0: got stall=%b start=%b code=%b want 1 1 10101",
               bus.stall_o, bus.md_start_o, bus.ALU_Operation_o);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.stall_o !== 1'b0 || bus.md_done_o !== 1'b1 || bus.ALU_Operation_o !== 5'b10101) begin
      errors++;
      $display("FAIL divz_c1: got stall=%b done=%b code=%b want 0 1 10101",
               bus.stall_o, bus.md_done_o, bus.ALU_Operation_o);
    end
    @(negedge clk);
    set_in(1'b0, 1'b0, 7'b0000000, 3'b000, 3'b000, 1'b0);
  endtask

  task automatic test_divu_full();
    int stall_n, start_n, first_done;
    stall_n = 0; start_n = 0; first_done = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c == 0) set_in(1'b1, 1'b0, 7'b0000001, 3'b000, 3'b101, 1'b0);
      if (c == 33) bus.valid_i = 1'b0;
      #1;
      if (bus.stall_o === 1'b1) stall_n++;
      if (bus.md_start_o === 1'b1) start_n++;
      if (bus.md_done_o === 1'b1 && first_done < 0) first_done = c;
      if (c == 16) begin
        checks++;
        if (bus.ALU_Operation_o !== 5'b10101 || bus.md_op_o !== 3'b101) begin
          errors++;
          $display("FAIL divu_mid: got code=%b op=%b want 10101 101", bus.ALU_Operation_o, bus.md_op_o);
        end
      end
    end
    checks++;
    if (stall_n != 32) begin
      errors++;
      $display("FAIL divu_stall_cycles: got %0d want 32", stall_n);
    end
    checks++;
    if (first_done != 32 || start_n != 1) begin
      errors++;
      $display("FAIL divu_done_cycle: got done@%0d starts=%0d want done@32 starts=1", first_done, start_n);
    end
  endtask

  task automatic test_back_to_back();
    int done_n;
    done_n = 0;
    for (int c = 0; c < 42; c++) begin
      @(negedge clk);
      if (c == 0) set_in(1'b1, 1'b0, 7'b0000001, 3'b000, 3'b110, 1'b0);
      if (c == 33) bus.funct3_i = 3'b011;
      if (c == 38) bus.valid_i = 1'b0;
      #1;
      if (bus.md_done_o === 1'b1) done_n++;
      case (c)
        5, 32: begin
          checks++;
          if (bus.md_op_o !== 3'b110 || bus.ALU_Operation_o !== 5'b10110) begin
            errors++;
            $display("FAIL b2b_rem_op c=%0d: got op=%b code=%b want 110 10110", c, bus.md_op_o, bus.ALU_Operation_o);
          end
          if (c == 32) begin
            checks++;
            if (bus.md_done_o !== 1'b1 || bus.stall_o !== 1'b0) begin
              errors++;
              $display("FAIL b2b_rem_done: got done=%b stall=%b want 1 0", bus.md_done_o, bus.stall_o);
            end
          end
        end
        33: begin
          checks++;
          if (bus.md_start_o !== 1'b1 || bus.stall_o !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second_start: got start=%b stall=%b want 1 1", bus.md_start_o, bus.stall_o);
          end
        end
        35: begin
          checks++;
          if (bus.md_op_o !== 3'b011 || bus.ALU_Operation_o !== 5'b10011 || bus.stall_o !== 1'b1) begin
            errors++;
            $display("FAIL b2b_mulhu_busy: got op=%b code=%b stall=%b want 011 10011 1",
                     bus.md_op_o, bus.ALU_Operation_o, bus.stall_o);
          end
        end
        37: begin
          checks++;
          if (bus.md_done_o !== 1'b1 || bus.stall_o !== 1'b0) begin
            errors++;
            $display("FAIL b2b_mulhu_done: got done=%b stall=%b want 1 0", bus.md_done_o, bus.stall_o);
          end
        end
        default: ;
      endcase
    end
    checks++;
    if (done_n != 2) begin
      errors++;
      $display("FAIL b2b_done_count: got %0d want 2", done_n);
    end
  endtask

  task automatic test_flush();
    int bad;
    // Flush while idle suppresses the start.
    @(negedge clk);
    set_in(1'b1, 1'b1, 7'b0000001, 3'b000, 3'b001, 1'b0);
    #1;
    checks++;
    if (bus.md_start_o !== 1'b0 || bus.stall_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle: got start=%b stall=%b want 0 0", bus.md_start_o, bus.stall_o);
    end
    @(negedge clk);
    set_in(1'b0, 1'b0, 7'b0000000, 3'b000, 3'b000, 1'b0);
    #1;
    checks++;
    if (bus.stall_o !== 1'b0 || bus.md_done_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle_next: got stall=%b done=%b want 0 0", bus.stall_o, bus.md_done_o);
    end
    // Flush in cycle 10 of a DIV.
    bad = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c == 0) set_in(1'b1, 1'b0, 7'b0000001, 3'b000, 3'b100, 1'b0);
      if (c == 10) bus.flush_i = 1'b1;
      if (c == 11) set_in(1'b0, 1'b0, 7'b0000000, 3'b000, 3'b000, 1'b0);
      #1;
      if (c == 9) begin
        checks++;
        if (bus.stall_o !== 1'b1) begin
          errors++;
          $display("FAIL flush_div_pre: got stall=%b want 1", bus.stall_o);
        end
      end else if (c == 10) begin
        checks++;
        if (bus.stall_o !== 1'b0 || bus.md_done_o !== 1'b0) begin
          errors++;
          $display("FAIL flush_div_cycle: got stall=%b done=%b want 0 0", bus.stall_o, bus.md_done_o);
        end
      end else if (c >= 11) begin
        if (bus.stall_o !== 1'b0 || bus.md_done_o !== 1'b0 || bus.md_start_o !== 1'b0) bad++;
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL flush_div_after: got %0d active cycles want 0", bad);
    end
    // Flush during the DONE cycle of a MUL kills the done pulse.
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 0) set_in(1'b1, 1'b0, 7'b0000001, 3'b000, 3'b010, 1'b0);
      if (c == 4) bus.flush_i = 1'b1;
      if (c == 5) set_in(1'b0, 1'b0, 7'b0000000, 3'b000, 3'b000, 1'b0);
      #1;
      if (c >= 4) begin
        checks++;
        if (bus.md_done_o !== 1'b0 || bus.stall_o !== 1'b0) begin
          errors++;
          $display("FAIL flush_done c=%0d: got done=%b stall=%b want 0 0", c, bus.md_done_o, bus.stall_o);
        end
      end
    end
  endtask

  task automatic test_valid_drop();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 0) set_in(1'b1, 1'b0, 7'b0000001, 3'b000, 3'b001, 1'b0);
      if (c == 1) bus.valid_i = 1'b0;
      #1;
      if (c == 3) begin
        checks++;
        if (bus.stall_o !== 1'b1) begin
          errors++;
          $display("FAIL vdrop_busy: got stall=%b want 1", bus.stall_o);
        end
      end
      if (c == 4) begin
        checks++;
        if (bus.md_done_o !== 1'b1 || bus.ALU_Operation_o !== 5'b10001) begin
          errors++;
          $display("FAIL vdrop_done: got done=%b code=%b want 1 10001", bus.md_done_o, bus.ALU_Operation_o);
        end
      end
    end
    @(negedge clk);
    set_in(1'b0, 1'b0, 7'b0000000, 3'b000, 3'b000, 1'b0);
  endtask

  task automatic test_reset_mid();
    int bad;
    @(negedge clk);
    set_in(1'b1, 1'b0, 7'b0000001, 3'b000, 3'b000, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (bus.stall_o !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_pre: got stall=%b want 1", bus.stall_o);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.stall_o, bus.md_start_o, bus.md_done_o, bus.md_op_o} !== 6'b0) begin
      errors++;
      $display("FAIL rstmid_now: got stall/start/done/op=%b%b%b/%b want 000/000",
               bus.stall_o, bus.md_start_o, bus.md_done_o, bus.md_op_o);
    end
    bus.valid_i = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    bad = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      #1;
      if (bus.stall_o !== 1'b0 || bus.md_done_o !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL rstmid_after: got %0d active cycles want 0", bad);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_decode();
    test_mul();
    test_divu_by_zero();
    test_divu_full();
    test_back_to_back();
    test_flush();
    test_valid_drop();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_control_md_seq.md
Name: alu_control_md_seq

Overview:
- Next-generation ALU control for the RISC-V core.
- Decodes {funct7, ALU_Op, funct3} into a widened ALU operation code. Adds RV32M multiply/divide support.
- Multi-cycle M-extension ops are handled by an internal sequencer. It freezes the pipeline through stall_o, issues start and done pulses to the multiply/divide unit, and supports flush.
- Sits between the main control unit and the ALU/MD datapath.

Parameters:
- ALU_OP_WIDTH, 5, width of ALU_Operation_o (must be >= 5).
- MUL_LATENCY, 4, stall cycles for MUL/MULH/MULHSU/MULHU (must be >= 2).
- DIV_LATENCY, 32, stall cycles for DIV/DIVU/REM/REMU (must be >= 2).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous reset, active-high.
- valid_i  input  1  instruction present in decode; held stable while stall_o=1.
- flush_i  input  1  kill current instruction (branch/jump redirect).
- funct7_i  input  7  instruction funct7 field.
- ALU_Op_i  input  3  ALU operation class from the control unit.
- funct3_i  input  3  instruction funct3 field.
- div_by_zero_i  input  1  divisor operand == 0; sampled at start.
- ALU_Operation_o  output  ALU_OP_WIDTH  operation code to ALU/MD unit.
- stall_o  output  1  hold PC and pipeline this cycle.
- md_start_o  output  1  one-cycle pulse: MD unit latch operands.
- md_op_o  output  3  MD sub-op (funct3), stable for the whole op.
- md_done_o  output  1  one-cycle pulse: MD result valid; write back this cycle.

Behaviour:
- Decode (combinational whenever the FSM is IDLE; codes are zero-extended to ALU_OP_WIDTH):
  - R (ALU_Op=000, funct7=0000000): f3 000 ADD=00000, 111 AND=00010, 110 OR=00011, 100 XOR=00100, 101 SRL=00110, 001 SLL=00111.
  - R, funct7=0100000: f3 000 SUB=00001, 101 SRA=01110.
  - I (ALU_Op=001): ADDI/ANDI/ORI/XORI take the same codes as R regardless of funct7. SRLI/SLLI require funct7=0000000. SRAI requires funct7=0100000 (01110).
  - LW/SW (ALU_Op=010, f3=010) and JALR (ALU_Op=111, f3=000) → 00000.
  - B (ALU_Op=101): f3 000 BEQ=01000, 001 BNE=01010, 100 BLT=01011, 101 BGE=01100.
  - LUI (ALU_Op=100) → 00101. JAL (ALU_Op=110) → 01101.
  - M (ALU_Op=000, funct7=0000001): code = {2'b10, funct3}. MUL=10000 ... REMU=10111. funct3[2]=1 selects divide.
  - Any unmatched combination → 00000.
- FSM states: IDLE, BUSY, DONE. A 6-bit down-counter cnt sized for max(MUL_LATENCY, DIV_LATENCY).
- IDLE:
  - If valid_i and M op and !flush_i: md_start_o=1 and stall_o=1 (combinational). Capture funct3 into md_op_o register.
  - If div_by_zero_i and divide op: next state DONE. Otherwise next state BUSY, with cnt = LAT-1, where LAT is MUL_LATENCY or DIV_LATENCY.
  - Non-M ops: stall_o=0, no state change.
- BUSY:
  - stall_o=1. ALU_Operation_o and md_op_o come from the captured op, not the live inputs.
  - If cnt==1: next state DONE; otherwise cnt decrements.
- DONE:
  - stall_o=0, md_done_o=1, ALU_Operation_o still from the captured op. Next state IDLE.
  - The instruction retires at this edge.
- Stall count per M op: exactly LAT cycles (1 cycle for a div-by-zero divide), then one DONE cycle. Total occupancy LAT+1.
- Back-to-back M ops: the next op starts in the IDLE cycle after DONE. There is no bubble beyond DONE.
- flush_i:
  - In IDLE it suppresses the start.
  - In BUSY or DONE: next state IDLE, md_done_o forced 0 in that cycle, stall_o drops in that same cycle.
- reset (async):
  - Forces IDLE, cnt=0, md_op_o=000.
  - While reset=1, stall_o, md_start_o and md_done_o are forced to 0.
  - Reset mid-op abandons the op with no done pulse.
- valid_i deasserted in BUSY (protocol violation): the sequence continues unaffected.

Test Plan:
- All non-M decodes: sweep funct7∈{0000000,0100000}, ALU_Op 0..7, funct3 0..7 → ALU_Operation_o matches the table (e.g. R f3=101 f7=0100000 → 01110), stall_o=0.
- MUL (funct7=0000001, ALU_Op=000, f3=000), default params → md_start_o pulses in cycle 0, stall_o=1 for cycles 0–3, md_done_o=1 in cycle 4, ALU_Operation_o=10000 throughout.
- DIVU with div_by_zero_i=1 → stall_o=1 for 1 cycle, md_done_o in cycle 1. Same op with div_by_zero_i=0 → 32 stall cycles, done in cycle 32.
- Back-to-back REM then MULHU → second md_start_o in the cycle right after the first md_done_o. md_op_o=110, then 011.
- flush_i in cycle 10 of DIV → next cycle IDLE, stall_o=0, no md_done_o. Async reset mid-MUL → all outputs 0 immediately.
